// File: rtl/mult_div_if.sv
// Start/operand/result bundle between the multicycle control FSM and mult_div_unit.
// When DIV_BY_ZERO_EXC_EN is defined, the bundle also carries the div0 flag.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    // Handshake: mult_start/div_start are single-cycle requests and are sampled only while busy=0.
    // done pulses for exactly one cycle per accepted request. hi/lo are valid from that cycle on.
    logic             mult_start;
    logic             div_start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             done;
    logic             busy;
    logic [2:0]       dbg_state;
`ifdef DIV_BY_ZERO_EXC_EN
    logic             div0;

    modport master (output mult_start, div_start, op_a, op_b,
                    input  hi, lo, done, busy, dbg_state, div0);
    modport slave  (input  mult_start, div_start, op_a, op_b,
                    output hi, lo, done, busy, dbg_state, div0);
`else
    modport master (output mult_start, div_start, op_a, op_b,
                    input  hi, lo, done, busy, dbg_state);
    modport slave  (input  mult_start, div_start, op_a, op_b,
                    output hi, lo, done, busy, dbg_state);
`endif
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 shift-add) / restoring divide, one bit per cycle.
// Optional DIV_BY_ZERO_EXC_EN: a zero divisor short-circuits to DONE and raises div0.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    mult_div_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic                 is_div_q, is_div_d;
    logic                 dz_q, dz_d;

    logic [WIDTH:0]       mult_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       rem_diff;
    logic [2*WIDTH-1:0]   prod;

    function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            a_q      <= a_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        a_d      = a_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        is_div_d = is_div_q;
        dz_d     = dz_q;

        // acc holds {partial product, remaining multiplier} or {remainder, quotient/dividend}.
        mult_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, mcand_q};
        prod     = neg_q ? -acc_q : acc_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.mult_start) begin
                    acc_d    = {{WIDTH{1'b0}}, abs_f(bus.op_b)};
                    mcand_d  = abs_f(bus.op_a);
                    neg_d    = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
                    is_div_d = 1'b0;
                    dz_d     = 1'b0;
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = S_MULT;
                end else if (bus.div_start) begin
                    acc_d    = {{WIDTH{1'b0}}, abs_f(bus.op_a)};
                    mcand_d  = abs_f(bus.op_b);
                    neg_d    = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
                    rneg_d   = bus.op_a[WIDTH-1];
                    a_d      = bus.op_a;
                    is_div_d = 1'b1;
                    dz_d     = (bus.op_b == '0);
                    cnt_d    = CNT_W'(WIDTH);
`ifdef DIV_BY_ZERO_EXC_EN
                    state_d  = (bus.op_b == '0) ? S_DONE : S_DIV;
`else
                    state_d  = S_DIV;
`endif
                end
            end
            S_MULT: begin
                acc_d = {mult_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_DIV: begin
                // Restoring step: keep the trial subtraction only when it did not borrow.
                if (!rem_diff[WIDTH]) acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else                  acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod;
                end else if (dz_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    lo_d = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
                    hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.done      = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.dbg_state = state_q;
`ifdef DIV_BY_ZERO_EXC_EN
    assign bus.div0      = (state_q == S_DONE) && is_div_q && dz_q;
`endif
endmodule
